// File: rtl/aud_play_engine.sv
// Multi-channel PCM playback engine: fetches interleaved frames from SRAM once per
// DAC LR-clock period and produces one output frame per period in fast, hold or
// linear-interpolation slow-play modes.
module aud_play_engine #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned SPEED_W = 4,
  parameter int unsigned NUM_CH  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_pause,
  input  logic                     i_stop,
  input  logic [1:0]               i_mode,
  input  logic [SPEED_W-1:0]       i_speed,
  input  logic [ADDR_W-1:0]        i_end_addr,
  input  logic                     i_daclrck,
  input  logic [DATA_W-1:0]        i_sram_data,
  output logic [ADDR_W-1:0]        o_sram_addr,
  output logic [NUM_CH*DATA_W-1:0] o_dac_data,
  output logic                     o_dac_valid,
  output logic [1:0]               o_state,
  output logic                     o_done
);

  localparam int unsigned SLOTS   = 2 * NUM_CH;
  localparam int unsigned CNT_W   = $clog2(SLOTS + 2);
  localparam int unsigned IW      = DATA_W + SPEED_W + 1;
  localparam int unsigned AX_W    = ADDR_W + 1;
  localparam int unsigned FRAME_W = NUM_CH * DATA_W;
  localparam int unsigned SAMP_W  = SLOTS * DATA_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] MODE_FAST = 2'd0;
  localparam logic [1:0] MODE_LIN  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                lrck_q;
  logic [1:0]          mode_q, mode_d;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [SPEED_W-1:0]  k_q, k_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [SAMP_W-1:0]   samp_q, samp_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [FRAME_W-1:0]  dac_data_q, dac_data_d;
  logic                dac_valid_q, dac_valid_d;
  logic                done_q, done_d;

  logic                tick_c;
  logic [CNT_W-1:0]    rlen_c;
  logic [1:0]          mode_lat_c;
  logic [SPEED_W-1:0]  speed_lat_c;
  logic [SAMP_W-1:0]   full_c;
  logic                b_hold_c;
  logic [FRAME_W-1:0]  interp_c;
  logic [FRAME_W-1:0]  out_c;
  logic [SPEED_W-1:0]  k_inc_c;
  logic [AX_W-1:0]     base_x_c;
  logic [AX_W-1:0]     nb_c;
  logic [SPEED_W-1:0]  nk_c;
  logic                end_hit_c;

  logic signed [IW-1:0] a_x, b_x, diff_x, prod_x, quo_x, sum_x;

  // Tick on LR-clock falling edge; reset/normalise the mode and speed to be latched.
  always_comb begin
    tick_c      = lrck_q & ~i_daclrck;
    rlen_c      = (mode_q == MODE_LIN) ? CNT_W'(SLOTS) : CNT_W'(NUM_CH);
    mode_lat_c  = (i_mode == 2'd3) ? MODE_FAST : i_mode;
    speed_lat_c = (i_speed == '0) ? SPEED_W'(1) : i_speed;
  end

  // Captured samples with the final word of the fetch taken live from the SRAM bus.
  always_comb begin
    full_c = samp_q;
    full_c[(int'(rlen_c) - 1) * DATA_W +: DATA_W] = i_sram_data;
    b_hold_c = ({1'b0, base_q} + AX_W'(NUM_CH)) > {1'b0, i_end_addr};
  end

  // Per-channel linear interpolation a + ((b-a)*k)/S, truncating toward zero.
  always_comb begin
    interp_c = '0;
    a_x      = '0;
    b_x      = '0;
    diff_x   = '0;
    prod_x   = '0;
    quo_x    = '0;
    sum_x    = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      a_x = IW'($signed(full_c[c * DATA_W +: DATA_W]));
      if (b_hold_c) begin
        b_x = a_x;
      end else begin
        b_x = IW'($signed(full_c[(int'(NUM_CH) + c) * DATA_W +: DATA_W]));
      end
      diff_x = b_x - a_x;
      prod_x = diff_x * IW'($signed({1'b0, k_q}));
      quo_x  = prod_x / IW'($signed({1'b0, speed_q}));
      sum_x  = a_x + quo_x;
      interp_c[c * DATA_W +: DATA_W] = sum_x[DATA_W-1:0];
    end
    out_c = (mode_q == MODE_LIN) ? interp_c : full_c[FRAME_W-1:0];
  end

  // Next frame base / phase and the end-of-data check on the advanced base.
  always_comb begin
    k_inc_c  = k_q + SPEED_W'(1);
    base_x_c = {1'b0, base_q};
    nk_c     = '0;
    if (mode_q == MODE_FAST) begin
      nb_c = base_x_c + AX_W'(NUM_CH) * AX_W'(speed_q);
    end else if (k_inc_c == speed_q) begin
      nb_c = base_x_c + AX_W'(NUM_CH);
    end else begin
      nb_c = base_x_c;
      nk_c = k_inc_c;
    end
    end_hit_c = (nb_c + AX_W'(NUM_CH - 1)) > {1'b0, i_end_addr};
  end

  // Playback FSM, fetch sequencer and output update.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    speed_d     = speed_q;
    base_d      = base_q;
    k_d         = k_q;
    busy_d      = busy_q;
    cyc_d       = cyc_q;
    samp_d      = samp_q;
    sram_addr_d = sram_addr_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!i_stop && !i_pause && i_start) begin
          state_d = ST_PLAY;
          base_d  = '0;
          k_d     = '0;
          mode_d  = mode_lat_c;
          speed_d = speed_lat_c;
          busy_d  = 1'b0;
          cyc_d   = '0;
        end
      end

      ST_PLAY: begin
        if (i_stop) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          cyc_d       = '0;
          dac_data_d  = '0;
          sram_addr_d = '0;
        end else if (i_pause) begin
          state_d    = ST_PAUSE;
          busy_d     = 1'b0;
          cyc_d      = '0;
          dac_data_d = '0;
        end else if (busy_q) begin
          cyc_d = cyc_q + CNT_W'(1);
          if (cyc_q < rlen_c) begin
            sram_addr_d = base_q + ADDR_W'(cyc_q);
          end
          if (cyc_q >= CNT_W'(2) && cyc_q <= rlen_c) begin
            samp_d[(int'(cyc_q) - 2) * DATA_W +: DATA_W] = i_sram_data;
          end
          if (cyc_q == rlen_c + CNT_W'(1)) begin
            busy_d      = 1'b0;
            cyc_d       = '0;
            dac_data_d  = out_c;
            dac_valid_d = 1'b1;
            base_d      = nb_c[ADDR_W-1:0];
            k_d         = nk_c;
            if (end_hit_c) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end else if (tick_c) begin
          busy_d      = 1'b1;
          cyc_d       = CNT_W'(1);
          sram_addr_d = base_q;
        end
      end

      ST_PAUSE: begin
        if (i_stop) begin
          state_d     = ST_IDLE;
          dac_data_d  = '0;
          sram_addr_d = '0;
        end else if (!i_pause && i_start) begin
          state_d = ST_PLAY;
          mode_d  = mode_lat_c;
          speed_d = speed_lat_c;
          busy_d  = 1'b0;
          cyc_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      lrck_q      <= 1'b0;
      mode_q      <= '0;
      speed_q     <= SPEED_W'(1);
      base_q      <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      cyc_q       <= '0;
      samp_q      <= '0;
      sram_addr_q <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lrck_q      <= i_daclrck;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      base_q      <= base_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      samp_q      <= samp_d;
      sram_addr_q <= sram_addr_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      done_q      <= done_d;
    end
  end

  assign o_sram_addr = sram_addr_q;
  assign o_dac_data  = dac_data_q;
  assign o_dac_valid = dac_valid_q;
  assign o_state     = state_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_aud_play_engine.sv
// Directed bench for aud_play_engine: SRAM model, LR-clock generator, output monitor.
module tb_aud_play_engine;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned NUM_CH  = 2;

  logic                     clk;
  logic                     i_rst_n;
  logic                     i_start;
  logic                     i_pause;
  logic                     i_stop;
  logic [1:0]               i_mode;
  logic [SPEED_W-1:0]       i_speed;
  logic [ADDR_W-1:0]        i_end_addr;
  logic                     lrck;
  logic [DATA_W-1:0]        sram_data;
  logic [ADDR_W-1:0]        o_sram_addr;
  logic [NUM_CH*DATA_W-1:0] o_dac_data;
  logic                     o_dac_valid;
  logic [1:0]               o_state;
  logic                     o_done;

  aud_play_engine #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SPEED_W(SPEED_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_pause     (i_pause),
    .i_stop      (i_stop),
    .i_mode      (i_mode),
    .i_speed     (i_speed),
    .i_end_addr  (i_end_addr),
    .i_daclrck   (lrck),
    .i_sram_data (sram_data),
    .o_sram_addr (o_sram_addr),
    .o_dac_data  (o_dac_data),
    .o_dac_valid (o_dac_valid),
    .o_state     (o_state),
    .o_done      (o_done)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // LR clock: 16 system clocks per period, changes on negedge
  initial begin
    lrck = 1'b1;
    forever begin
      repeat (8) @(negedge clk);
      lrck = ~lrck;
    end
  end

  // SRAM: data valid one cycle after the address
  logic [DATA_W-1:0] mem [0:63];
  always @(posedge clk) sram_data <= mem[o_sram_addr[5:0]];

  // Monitor: records every valid frame and its distance from the tick cycle
  logic [31:0]       vq_data[$];
  int                vq_lat[$];
  int                done_cnt = 0;
  int                since_tick = 99;
  int                pause_addr_chg = 0;
  logic              lr_prev_s = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;

  always @(posedge clk) begin
    #1;
    if (lr_prev_s && !lrck) since_tick = 1;
    else since_tick = since_tick + 1;
    lr_prev_s = lrck;
    if (o_dac_valid) begin
      vq_data.push_back(o_dac_data);
      vq_lat.push_back(since_tick);
    end
    if (o_done) done_cnt = done_cnt + 1;
    if (o_state == 2'd2 && o_sram_addr != last_addr) pause_addr_chg = pause_addr_chg + 1;
    last_addr = o_sram_addr;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fr(input int c1, input int c0);
    return {16'(c1), 16'(c0)};
  endfunction

  task automatic pulse_start();
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n0, input int budget);
    int i = 0;
    while (done_cnt == n0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt > n0), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valids(input string tag, input int n, input int budget);
    int i = 0;
    while (vq_data.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_valid_seen"}, 64'(vq_data.size() >= n), 64'd1);
  endtask

  task automatic wait_tick2(input string tag);
    int i = 0;
    @(negedge clk);
    while (since_tick != 2 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_tick_seen"}, 64'(since_tick == 2), 64'd1);
  endtask

  task automatic check_frames(input string tag, input int v0, input int lat);
    chk({tag, "_count"}, 64'(vq_data.size() - v0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [63:0] g;
      int          l;
      if (v0 + i < vq_data.size()) begin
        g = 64'(vq_data[v0 + i]);
        l = vq_lat[v0 + i];
      end else begin
        g = 64'h1_0000_0000;
        l = -1;
      end
      chk($sformatf("%s_f%0d", tag, i), g, 64'(exp_q[i]));
      chk($sformatf("%s_lat%0d", tag, i), 64'(l), 64'(lat));
    end
  endtask

  // Overall time bound
  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  int v0;
  int n0;
  int pv;
  int pc0;

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_pause    = 1'b0;
    i_stop     = 1'b0;
    i_mode     = 2'd0;
    i_speed    = 4'd1;
    i_end_addr = 20'd7;
    for (int i = 0; i < 64; i++) mem[i] = 16'(i);
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_data", 64'(o_dac_data), 64'd0);
    chk("rst_addr", 64'(o_sram_addr), 64'd0);
    chk("rst_valid", 64'(o_dac_valid), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_state", 64'(o_state), 64'd0);

    // 1: mode 0, speed 1, end 7
    v0 = vq_data.size(); n0 = done_cnt;
    pulse_start();
    wait_done("t1", n0, 600);
    exp_q = {fr(1, 0), fr(3, 2), fr(5, 4), fr(7, 6)};
    check_frames("t1", v0, 4);
    chk("t1_state", 64'(o_state), 64'd0);
    chk("t1_hold", 64'(o_dac_data), 64'(fr(7, 6)));
    chk("t1_ndone", 64'(done_cnt - n0), 64'd1);

    // 2: mode 0, speed 3, end 15
    i_speed = 4'd3; i_end_addr = 20'd15;
    v0 = vq_data.size(); n0 = done_cnt;
    pulse_start();
    wait_done("t2", n0, 600);
    exp_q = {fr(1, 0), fr(7, 6), fr(13, 12)};
    check_frames("t2", v0, 4);
    chk("t2_state", 64'(o_state), 64'd0);

    // 3: mode 1, speed 4, hold
    mem[0] = 16'd100; mem[1] = 16'd1; mem[2] = 16'd200; mem[3] = 16'd2;
    i_mode = 2'd1; i_speed = 4'd4; i_end_addr = 20'd3;
    v0 = vq_data.size(); n0 = done_cnt;
    pulse_start();
    wait_done("t3", n0, 600);
    exp_q = {fr(1, 100), fr(1, 100), fr(1, 100), fr(1, 100),
             fr(2, 200), fr(2, 200), fr(2, 200), fr(2, 200)};
    check_frames("t3", v0, 4);

    // 4: mode 2, speed 4, interpolation with truncation and last-frame hold
    mem[0] = 16'd0; mem[1] = 16'd0; mem[2] = 16'hFF9C; mem[3] = 16'd7;
    i_mode = 2'd2; i_speed = 4'd4; i_end_addr = 20'd3;
    v0 = vq_data.size(); n0 = done_cnt;
    pulse_start();
    wait_done("t4", n0, 600);
    exp_q = {fr(0, 0), fr(1, -25), fr(3, -50), fr(5, -75),
             fr(7, -100), fr(7, -100), fr(7, -100), fr(7, -100)};
    check_frames("t4", v0, 6);

    // 5: mode 2, speed 3, pause after 2nd frame for 10 ticks, then resume
    mem[0] = 16'd0;   mem[1] = 16'd10; mem[2] = 16'd100; mem[3] = 16'd20;
    mem[4] = 16'd200; mem[5] = 16'd30; mem[6] = 16'd300; mem[7] = 16'd40;
    i_mode = 2'd2; i_speed = 4'd3; i_end_addr = 20'd7;
    v0 = vq_data.size(); n0 = done_cnt;
    pulse_start();
    wait_valids("t5", v0 + 2, 200);
    i_pause = 1'b1;
    @(negedge clk) i_pause = 1'b0;
    pv = vq_data.size(); pc0 = pause_addr_chg;
    repeat (160) @(negedge clk);
    chk("t5_pause_state", 64'(o_state), 64'd2);
    chk("t5_pause_data", 64'(o_dac_data), 64'd0);
    chk("t5_pause_nvalid", 64'(vq_data.size() - pv), 64'd0);
    chk("t5_pause_reads", 64'(pause_addr_chg - pc0), 64'd0);
    pulse_start();
    wait_done("t5", n0, 1000);
    exp_q = {fr(10, 0), fr(13, 33), fr(16, 66),
             fr(20, 100), fr(23, 133), fr(26, 166),
             fr(30, 200), fr(33, 233), fr(36, 266),
             fr(40, 300), fr(40, 300), fr(40, 300)};
    check_frames("t5", v0, 6);

    // 6a: stop together with pause in the middle of a fetch
    i_mode = 2'd2; i_speed = 4'd1; i_end_addr = 20'd63;
    v0 = vq_data.size(); n0 = done_cnt;
    pulse_start();
    wait_valids("t6a", v0 + 1, 200);
    chk("t6a_first", 64'(o_dac_data), 64'(fr(10, 0)));
    wait_tick2("t6a");
    i_stop = 1'b1; i_pause = 1'b1;
    @(negedge clk);
    i_stop = 1'b0; i_pause = 1'b0;
    @(negedge clk);
    chk("t6a_state", 64'(o_state), 64'd0);
    chk("t6a_data", 64'(o_dac_data), 64'd0);
    chk("t6a_addr", 64'(o_sram_addr), 64'd0);
    repeat (40) @(negedge clk);
    chk("t6a_nvalid", 64'(vq_data.size() - v0), 64'd1);
    chk("t6a_ndone", 64'(done_cnt - n0), 64'd0);

    // 6b: asynchronous reset in the middle of a fetch
    v0 = vq_data.size(); n0 = done_cnt;
    pulse_start();
    wait_valids("t6b", v0 + 1, 200);
    wait_tick2("t6b");
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6b_state", 64'(o_state), 64'd0);
    chk("t6b_data", 64'(o_dac_data), 64'd0);
    chk("t6b_addr", 64'(o_sram_addr), 64'd0);
    chk("t6b_valid", 64'(o_dac_valid), 64'd0);
    chk("t6b_done", 64'(o_done), 64'd0);
    @(negedge clk) i_rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6b_nvalid", 64'(vq_data.size() - v0), 64'd1);
    chk("t6b_idle", 64'(o_state), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
